inst_fetcher: RTL and testbench

- Front-end stage directly upstream of the instruction decoder.
- Fetches 32-bit RISC-V instructions from the memory controller one at a time, buffers them in an instruction queue, and presents the head instruction and its PC to the decode/dispatch stage.
- Predicts every fetch as sequential (PC+4).
- Recovers from ROB-signalled mispredictions by flushing the queue, discarding any in-flight fetch and redirecting the PC.

---
 rtl/inst_fetcher_pkg.sv | 27 ++
 rtl/inst_fetcher_queue.sv | 89 ++++++++
 rtl/inst_fetcher.sv | 117 +++++++++++
 tb/tb_inst_fetcher.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared types, sizes and FSM encodings for the instruction fetch front end.
package inst_fetcher_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam int IF_IQ_DEPTH = 16;
    localparam int IF_IQ_PTR_W = 4;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_WAIT    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Every fetch is predicted sequential.
    function automatic addr_t next_seq_pc(input addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular instruction queue holding {pc, inst} pairs for the decoder.
// Pointers wrap naturally because the depth is a power of two.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH = IF_IQ_DEPTH,
    parameter int PTR_W = IF_IQ_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [31:0]      push_pc_i,
    input  logic [31:0]      push_inst_i,
    input  logic             pop_i,
    output logic [31:0]      head_pc_o,
    output logic [31:0]      head_inst_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    inst_t pc_mem   [DEPTH];
    inst_t inst_mem [DEPTH];

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

    // Head is read straight from storage; a constant zero while empty keeps it stable.
    assign head_pc_o   = empty_o ? '0 : pc_mem[head_q];
    assign head_inst_o = empty_o ? '0 : inst_mem[head_q];

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_push = push_i && !flush_i;
        do_pop  = pop_i && !empty_o && !flush_i;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail_q]   <= push_pc_i;
            inst_mem[tail_q] <= push_inst_i;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding sequential fetch at a time,
// buffered in an instruction queue, with ROB-driven rollback recovery.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH = IF_IQ_DEPTH,
    parameter int          IQ_PTR_W = IF_IQ_PTR_W,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        rollback,
    input  logic [31:0] rollback_pc
);

    if_state_e state_q, state_d;
    addr_t     pc_q, pc_d;
    addr_t     addr_q, addr_d;

    logic              iq_push;
    logic              iq_pop;
    logic              iq_flush;
    logic [IQ_PTR_W:0] iq_count;
    logic              iq_full;
    logic              iq_empty;

    assign mem_req_valid = (state_q == IF_WAIT);
    assign mem_req_addr  = addr_q;
    assign out_valid     = (iq_count != '0);

    // Queue side effects only happen while enabled; rollback squashes the pop.
    assign iq_flush = rdy && rollback;
    assign iq_pop   = rdy && out_ready && !iq_empty && !rollback;

    // Fetch FSM next-state, pc redirect and push decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        iq_push = FALSE;
        if (rdy) begin
            case (state_q)
                IF_IDLE: begin
                    if (rollback) begin
                        pc_d = rollback_pc;
                    end else if (!iq_full) begin
                        state_d = IF_WAIT;
                        addr_d  = pc_q;
                    end
                end
                IF_WAIT: begin
                    if (rollback) begin
                        pc_d    = rollback_pc;
                        state_d = mem_resp_valid ? IF_IDLE : IF_DISCARD;
                    end else if (mem_resp_valid) begin
                        iq_push = TRUE;
                        pc_d    = next_seq_pc(pc_q);
                        state_d = IF_IDLE;
                    end
                end
                IF_DISCARD: begin
                    if (rollback) begin
                        pc_d = rollback_pc;
                    end
                    // The stale response is what we are waiting for, rollback or not.
                    if (mem_resp_valid) begin
                        state_d = IF_IDLE;
                    end
                end
                default: begin
                    state_d = IF_IDLE;
                end
            endcase
        end
    end

    // FSM, pc and request-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    inst_queue #(
        .DEPTH (IQ_DEPTH),
        .PTR_W (IQ_PTR_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (iq_flush),
        .push_i      (iq_push),
        .push_pc_i   (pc_q),
        .push_inst_i (mem_resp_inst),
        .pop_i       (iq_pop),
        .head_pc_o   (out_pc),
        .head_inst_o (out_inst),
        .count_o     (iq_count),
        .full_o      (iq_full),
        .empty_o     (iq_empty)
    );

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a small programmable memory responder.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_inst;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        rollback;
    logic [31:0] rollback_pc;

    int total = 0;
    int bad   = 0;

    // Memory responder state
    bit auto_mem = 1'b0;
    int lat      = 1;
    int mem_cnt  = 0;
    bit prev_req = 1'b0;
    int req_rise = 0;

    inst_fetcher dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_inst  (mem_resp_inst),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .rollback       (rollback),
        .rollback_pc    (rollback_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wrd(input logic [31:0] a);
        return 32'h00000013 ^ (a << 8);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One clock; sample #1 after the edge and update the memory responder.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req_valid && !prev_req) req_rise++;
        prev_req = mem_req_valid;
        if (auto_mem) begin
            if (mem_resp_valid) begin
                mem_resp_valid = 1'b0;
                mem_cnt = 0;
            end else if (mem_req_valid) begin
                if (mem_cnt == lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_inst  = wrd(mem_req_addr);
                end else begin
                    mem_cnt++;
                end
            end
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!mem_req_valid && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, {31'd0, mem_req_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        int          n;
        int          r0;

        rst = 1'b1; rdy = 1'b1; out_ready = 1'b0; rollback = 1'b0;
        rollback_pc = 32'h0; mem_resp_valid = 1'b0; mem_resp_inst = 32'h0;
        repeat (3) tick();
        check_val("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check_val("rst_req_addr", mem_req_addr, 32'h0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_inst", out_inst, 32'h0);
        check_val("rst_out_pc", out_pc, 32'h0);

        // 1: first fetch, response one cycle after the request
        rst = 1'b0; auto_mem = 1'b1; lat = 1; mem_cnt = 0;
        tick();
        check_val("t1_req0_valid", {31'd0, mem_req_valid}, 32'd1);
        check_val("t1_req0_addr", mem_req_addr, 32'h0);
        tick();
        check_val("t1_no_out_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check_val("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check_val("t1_out_pc", out_pc, 32'h0);
        check_val("t1_out_inst", out_inst, 32'h00000013);
        check_val("t1_idle_gap", {31'd0, mem_req_valid}, 32'd0);
        tick();
        check_val("t1_req1_valid", {31'd0, mem_req_valid}, 32'd1);
        check_val("t1_req1_addr", mem_req_addr, 32'h4);

        // 2: fill the queue, then free exactly one slot
        repeat (100) tick();
        check_val("t2_full_no_req", {31'd0, mem_req_valid}, 32'd0);
        check_val("t2_head_pc", out_pc, 32'h0);
        r0 = req_rise;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t2_pop_head", out_pc, 32'h4);
        tick();
        check_val("t2_refill_req", {31'd0, mem_req_valid}, 32'd1);
        check_val("t2_refill_addr", mem_req_addr, 32'h40);
        repeat (10) tick();
        check_val("t2_one_request", req_rise - r0, 32'd1);
        check_val("t2_full_again", {31'd0, mem_req_valid}, 32'd0);

        // Drain all 16 entries (0x4..0x40); memory responder off
        auto_mem = 1'b0; mem_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_val("drain_valid", {31'd0, out_valid}, 32'd1);
            check_val("drain_pc", out_pc, 32'h4 + 32'(i) * 4);
            check_val("drain_inst", out_inst, wrd(32'h4 + 32'(i) * 4));
            tick();
        end
        out_ready = 1'b0;
        check_val("drain_empty", {31'd0, out_valid}, 32'd0);

        // 3: rollback while waiting for 0x44, stale response arrives later
        check_val("t3_wait_valid", {31'd0, mem_req_valid}, 32'd1);
        check_val("t3_wait_addr", mem_req_addr, 32'h44);
        rollback = 1'b1; rollback_pc = 32'h100;
        tick();
        rollback = 1'b0;
        check_val("t3_discard_noreq", {31'd0, mem_req_valid}, 32'd0);
        repeat (2) tick();
        check_val("t3_discard_hold", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_inst = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        check_val("t3_stale_dropped", {31'd0, out_valid}, 32'd0);
        tick();
        check_val("t3_redirect_valid", {31'd0, mem_req_valid}, 32'd1);
        check_val("t3_redirect_addr", mem_req_addr, 32'h100);
        check_val("t3_still_empty", {31'd0, out_valid}, 32'd0);
        mem_cnt = 0; auto_mem = 1'b1;
        wait_valid("t3_wait_out", 10);
        check_val("t3_out_pc", out_pc, 32'h100);
        check_val("t3_out_inst", out_inst, wrd(32'h100));

        // 4: rollback coinciding with response and pop, 3 entries queued
        auto_mem = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_inst = wrd(32'h104);
        tick();
        mem_resp_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_inst = wrd(32'h108);
        tick();
        mem_resp_valid = 1'b0;
        tick();
        check_val("t4_wait_addr", mem_req_addr, 32'h10C);
        check_val("t4_head_pc", out_pc, 32'h100);
        mem_resp_valid = 1'b1; mem_resp_inst = wrd(32'h10C);
        out_ready = 1'b1; rollback = 1'b1; rollback_pc = 32'h200;
        tick();
        mem_resp_valid = 1'b0; out_ready = 1'b0; rollback = 1'b0;
        check_val("t4_flushed", {31'd0, out_valid}, 32'd0);
        check_val("t4_idle_noreq", {31'd0, mem_req_valid}, 32'd0);
        tick();
        check_val("t4_no_discard", {31'd0, mem_req_valid}, 32'd1);
        check_val("t4_new_addr", mem_req_addr, 32'h200);
        mem_resp_valid = 1'b1; mem_resp_inst = wrd(32'h200);
        tick();
        mem_resp_valid = 1'b0;
        check_val("t4_out_valid", {31'd0, out_valid}, 32'd1);
        check_val("t4_out_pc", out_pc, 32'h200);

        // 5: continuous push/pop across pointer wrap, 40 instructions
        out_ready = 1'b1; mem_cnt = 0; auto_mem = 1'b1;
        exp_pc = 32'h200; n = 0;
        for (int c = 0; c < 600 && n < 40; c++) begin
            if (out_valid) begin
                check_val("t5_stream_pc", out_pc, exp_pc);
                check_val("t5_stream_inst", out_inst, wrd(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n++;
                if (n == 40) break;
            end
            tick();
        end
        check_val("t5_count", 32'(n), 32'd40);
        out_ready = 1'b0;
        auto_mem = 1'b0;

        // 6: rdy low mid-WAIT with a response pulse that must be ignored
        wait_req("t6_req", 10);
        check_val("t6_addr", mem_req_addr, 32'h2A0);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mem_resp_valid = 1'b1; mem_resp_inst = 32'hBADBAD00;
            end
            tick();
            mem_resp_valid = 1'b0;
            check_val("t6_hold_req", {31'd0, mem_req_valid}, 32'd1);
            check_val("t6_hold_addr", mem_req_addr, 32'h2A0);
            check_val("t6_hold_pc", out_pc, 32'h29C);
        end
        rdy = 1'b1;
        tick();
        check_val("t6_still_wait", {31'd0, mem_req_valid}, 32'd1);
        mem_resp_valid = 1'b1; mem_resp_inst = wrd(32'h2A0);
        tick();
        mem_resp_valid = 1'b0;
        check_val("t6_done_idle", {31'd0, mem_req_valid}, 32'd0);
        check_val("t6_head_kept", out_pc, 32'h29C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t6_next_pc", out_pc, 32'h2A0);
        check_val("t6_next_inst", out_inst, wrd(32'h2A0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
